// File: rtl/pixel_feeder.sv
// pixel_feeder: buffers 24-bit RGB pixels from a producer in a small FWFT FIFO and releases
// one pixel per active-video (de) cycle on the pixel clock. Frames are locked to the
// sof-tagged word; FILL is substituted on starvation or misalignment.
//
// Ports:
//   clk            pixel clock (sole clock)
//   rst            asynchronous active-low reset
//   in_valid       producer word valid
//   in_data        producer pixel {B,G,R}
//   in_sof         word is first pixel of a frame
//   in_ready       FIFO not full; a word is pushed when in_valid && in_ready
//   frame_start    timing pulse on the cycle of pixel (0,0)
//   de             active video; one pixel consumed per de cycle
//   pix_out        pixel for the current de cycle (combinational)
//   level          FIFO occupancy
//   clr_stats      synchronous clear of counters and sticky flag
//   underflow      sticky: a FILL was substituted while streaming
//   underflow_cnt  FILL pixels emitted while streaming, saturating
//   resync_cnt     frame_start seen with misaligned head, saturating
module pixel_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter logic [23:0] FILL  = 24'h000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [23:0]              in_data,
  input  logic                     in_sof,
  output logic                     in_ready,
  input  logic                     frame_start,
  input  logic                     de,
  output logic [23:0]              pix_out,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stats,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt,
  output logic [7:0]               resync_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  typedef enum logic [1:0] {
    StSync,
    StWait,
    StStream
  } state_e;

  state_e state_q, state_d;

  // Storage holds {sof, data}.
  logic [24:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        emit;
  logic        uf_inc;
  logic        rs_inc;
  logic [24:0] head;
  logic        head_sof;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_sof = head[24];
  assign level    = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_sof, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= StSync;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // pop: head leaves the FIFO; emit: the popped head also goes out on pix_out
  // (SYNC discards without emitting).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    emit    = 1'b0;
    uf_inc  = 1'b0;
    rs_inc  = 1'b0;
    unique case (state_q)
      StSync: begin
        if (!empty) begin
          if (head_sof) begin
            state_d = StWait;
          end else begin
            pop = 1'b1;
          end
        end
      end
      StWait: begin
        if (frame_start) begin
          state_d = StStream;
          if (de && !empty) begin
            pop  = 1'b1;
            emit = 1'b1;
          end
        end
      end
      StStream: begin
        if (de && frame_start) begin
          if (empty) begin
            uf_inc  = 1'b1;
            state_d = StSync;
          end else if (head_sof) begin
            pop  = 1'b1;
            emit = 1'b1;
          end else begin
            rs_inc  = 1'b1;
            state_d = StSync;
          end
        end else if (de) begin
          // A sof head mid-frame means the producer's frame ran short: hold it for
          // the next frame_start and pad the rest of this frame.
          if (empty || head_sof) begin
            uf_inc = 1'b1;
          end else begin
            pop  = 1'b1;
            emit = 1'b1;
          end
        end
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  assign pix_out = emit ? head[23:0] : FILL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      resync_cnt    <= '0;
    end else if (clr_stats) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      resync_cnt    <= '0;
    end else begin
      if (uf_inc) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) begin
          underflow_cnt <= underflow_cnt + 16'd1;
        end
      end
      if (rs_inc && (resync_cnt != 8'hFF)) begin
        resync_cnt <= resync_cnt + 8'd1;
      end
    end
  end

endmodule
